mole_datapath: RTL

Game datapath for the whack-a-mole game. It consumes the 4-bit game state from the game FSM and produces the FSM's control, timer and delay inputs. Internally it runs the tick prescaler, the game countdown, the inter-mole gap timer and the mole window timer. It also synchronises the four mole buttons and keeps score and miss counts for the display path.

---
 rtl/mole_datapath.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mole_datapath.sv
// Whack-a-mole game datapath: tick prescaler, game countdown, gap and mole-window timers,
// button synchronisers and score/miss counters feeding the game FSM.
module mole_datapath #(
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned GAME_TICKS = 600,
    parameter int unsigned GAP_TICKS  = 5,
    parameter int unsigned MOLE_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    input  logic [3:0] btn,
    output logic       control_signal,
    output logic       timer_signal,
    output logic       delay_done,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [9:0] time_left,
    output logic [3:0] mole_leds,
    output logic       hit_pulse
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int unsigned MW = (MOLE_TICKS > 0) ? $clog2(MOLE_TICKS + 1) : 1;

    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GapLast   = GW'(GAP_TICKS);
    localparam logic [MW-1:0] MoleLast  = MW'(MOLE_TICKS);
    localparam logic [9:0]    GameLoad  = 10'(GAME_TICKS);

    typedef enum logic [1:0] {PhStart, PhGame, PhMole, PhOver} phase_e;

    phase_e     phase;
    logic [1:0] mole_idx;

    logic [3:0]    sync1_q, sync2_q, sync3_q, press_q;
    logic [3:0]    state_q;
    logic          entry;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [9:0]    time_q, time_d;
    logic          timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [MW-1:0] mole_q, mole_d;
    logic          wait_q, wait_d, wait_eff;
    logic          hit, timeout, gap_done;
    logic          ctrl_q, ctrl_d;
    logic          delay_q, delay_d;
    logic          hit_q, hit_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    miss_q, miss_d;
    logic [3:0]    leds_q, leds_d;

    // Out-of-range state codes decode as Start.
    always_comb begin
        phase    = PhStart;
        mole_idx = 2'd0;
        case (state)
            4'd1: phase = PhGame;
            4'd2, 4'd3, 4'd4, 4'd5: begin
                phase    = PhMole;
                mole_idx = state[1:0] - 2'd2;
            end
            4'd6: phase = PhOver;
            default: phase = PhStart;
        endcase
    end

    assign entry    = (state != state_q);
    assign wait_eff = wait_q && !entry;

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (phase == PhStart) begin
            presc_d = '0;
        end else if (presc_q == PrescLast) begin
            presc_d = '0;
            tick    = 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        time_d = time_q;
        if (phase == PhStart) begin
            time_d = GameLoad;
        end else if ((phase == PhGame || phase == PhMole) && tick && time_q != '0) begin
            time_d = time_q - 1'b1;
        end
        timer_d = (phase != PhStart) && (time_q == '0);
    end

    // Gap and mole counters saturate at their limits so they cannot wrap while waiting.
    always_comb begin
        gap_d = gap_q;
        if (phase != PhGame || entry) begin
            gap_d = '0;
        end else if (tick && gap_q != GapLast) begin
            gap_d = gap_q + 1'b1;
        end

        mole_d = mole_q;
        if (phase != PhMole || entry) begin
            mole_d = '0;
        end else if (tick && mole_q != MoleLast) begin
            mole_d = mole_q + 1'b1;
        end
    end

    always_comb begin
        hit      = (phase == PhMole) && press_q[mole_idx] && !wait_eff;
        timeout  = (phase == PhMole) && !entry && (mole_q == MoleLast) && !wait_eff && !hit;
        gap_done = (phase == PhGame) && !entry && (gap_q == GapLast) && !wait_eff &&
                   (time_q != '0);
        ctrl_d   = hit || timeout || gap_done;
        delay_d  = gap_done;
        hit_d    = hit;

        wait_d = wait_q;
        if (ctrl_d) begin
            wait_d = 1'b1;
        end else if (entry || phase == PhStart) begin
            wait_d = 1'b0;
        end

        score_d = score_q;
        miss_d  = miss_q;
        if (phase == PhStart) begin
            score_d = '0;
            miss_d  = '0;
        end else begin
            if (hit && score_q != 8'hFF) score_d = score_q + 1'b1;
            if (timeout && miss_q != 8'hFF) miss_d = miss_q + 1'b1;
        end

        leds_d = leds_q;
        if (phase != PhMole || ctrl_d) begin
            leds_d = '0;
        end else if (entry) begin
            leds_d = 4'b0001 << mole_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            press_q <= '0;
            state_q <= '0;
            presc_q <= '0;
            time_q  <= GameLoad;
            timer_q <= 1'b0;
            gap_q   <= '0;
            mole_q  <= '0;
            wait_q  <= 1'b0;
            ctrl_q  <= 1'b0;
            delay_q <= 1'b0;
            hit_q   <= 1'b0;
            score_q <= '0;
            miss_q  <= '0;
            leds_q  <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            press_q <= sync2_q & ~sync3_q;
            state_q <= state;
            presc_q <= presc_d;
            time_q  <= time_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            mole_q  <= mole_d;
            wait_q  <= wait_d;
            ctrl_q  <= ctrl_d;
            delay_q <= delay_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            leds_q  <= leds_d;
        end
    end

    assign control_signal = ctrl_q;
    assign timer_signal   = timer_q;
    assign delay_done     = delay_q;
    assign score          = score_q;
    assign misses         = miss_q;
    assign time_left      = time_q;
    assign mole_leds      = leds_q;
    assign hit_pulse      = hit_q;

endmodule
